// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter timer with prescaler, pause and auto-reload
module countdown_timer #(
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_value,
    input  logic               start,
    input  logic               pause,
    input  logic               auto_reload,
    input  logic [PRESC_W-1:0] tick_div,
    output logic [WIDTH-1:0]   count_output,
    output logic               running,
    output logic               expired,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   count;
    logic [WIDTH-1:0]   reload_reg;
    logic [PRESC_W-1:0] presc_cnt;
    logic               run_active;
    logic               tick;
    logic               terminal;
    logic               reload_ok;
    logic               start_ok;

    // >= rather than == so a live shrink of tick_div below presc_cnt still wraps
    assign run_active = (state == RUN) && !load && !pause;
    assign tick       = run_active && (presc_cnt >= tick_div);
    assign terminal   = tick && (count == WIDTH'(1));
    assign reload_ok  = auto_reload && (reload_reg != '0);
    assign start_ok   = start && !load && !pause && (state != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (load) begin
            next_state = IDLE;
        end else if (state == RUN) begin
            if (pause) begin
                next_state = PAUSED;
            end else if (terminal && !reload_ok) begin
                next_state = EXPIRED;
            end
        end else if (start_ok) begin
            next_state = (count != '0) ? RUN : EXPIRED;
        end
    end

    always_comb begin
        running = (state == RUN);
        expired = (state == EXPIRED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            reload_reg <= '0;
            presc_cnt  <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                count      <= load_value;
                reload_reg <= load_value;
                presc_cnt  <= '0;
            end else if (run_active) begin
                if (tick) begin
                    presc_cnt <= '0;
                    if (count > WIDTH'(1)) begin
                        count <= count - WIDTH'(1);
                    end else begin
                        done  <= 1'b1;
                        count <= reload_ok ? reload_reg : '0;
                    end
                end else begin
                    presc_cnt <= presc_cnt + PRESC_W'(1);
                end
            end else if (start_ok && (state != PAUSED)) begin
                presc_cnt <= '0;
            end
        end
    end

    assign count_output = count;

endmodule
